// File: rtl/armleocpu_fetch_bridge.sv
// armleocpu_fetch_bridge: answers fetch cache commands from a single-outstanding read bus with a one-entry buffer.
module armleocpu_fetch_bridge #(
  parameter int          INIT_CYCLES = 4,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE    = 32'h0001_0000,
  parameter int          TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        c_reset_done,
  output logic        m_req,
  output logic [31:0] m_addr,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic [31:0] m_rdata
);
  localparam logic [3:0] CMD_EXECUTE = 4'd1, CMD_FLUSH_ALL = 4'd4;
  localparam logic [3:0] RESP_IDLE = 4'd0, RESP_WAIT = 4'd1, RESP_DONE = 4'd2,
                         RESP_ACCESSFAULT = 4'd3, RESP_MISSALIGNED = 4'd5;
  typedef enum logic [1:0] {S_INIT, S_READY, S_BUS} state_t;
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_init_cnt, w_init_nxt;
  logic [15:0] r_tmo_cnt, w_tmo_nxt;
  logic [3:0]  r_resp, w_resp_nxt;
  logic [31:0] r_data, w_data_nxt, r_addr, w_addr_nxt, r_buf_addr, w_buf_addr_nxt, r_buf_data, w_buf_data_nxt;
  logic        r_done, w_done_nxt, r_req, w_req_nxt, r_buf_valid, w_buf_valid_nxt;
  logic        w_in_range, w_hit, w_fault;
  // 33-bit window check so MEM_BASE+MEM_SIZE may reach 2^32
  assign w_in_range = ({1'b0, c_address} >= {1'b0, MEM_BASE}) &&
                      ({1'b0, c_address} < ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
  assign w_hit      = r_buf_valid && (r_buf_addr == c_address);
  assign w_fault    = m_err || (!m_ack && r_tmo_cnt == 16'(TIMEOUT - 1));
  always_comb begin
    w_state_nxt     = r_state;
    w_init_nxt      = r_init_cnt;
    w_tmo_nxt       = r_tmo_cnt;
    w_resp_nxt      = r_resp;
    w_data_nxt      = r_data;
    w_done_nxt      = r_done;
    w_req_nxt       = r_req;
    w_addr_nxt      = r_addr;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_data_nxt  = r_buf_data;
    case (r_state)
      S_INIT: begin
        if (r_init_cnt == 8'(INIT_CYCLES - 1)) begin
          w_state_nxt = S_READY;
          w_done_nxt  = 1'b1;
        end else
          w_init_nxt = r_init_cnt + 8'd1;
      end
      S_READY: begin
        w_resp_nxt = RESP_IDLE;
        if (c_cmd == CMD_FLUSH_ALL) begin
          w_buf_valid_nxt = 1'b0;
          w_resp_nxt      = RESP_DONE;
        end else if (c_cmd == CMD_EXECUTE) begin
          if (c_address[1:0] != 2'b00)
            w_resp_nxt = RESP_MISSALIGNED;
          else if (!w_in_range)
            w_resp_nxt = RESP_ACCESSFAULT;
          else if (w_hit) begin
            w_resp_nxt = RESP_DONE;
            w_data_nxt = r_buf_data;
          end else begin
            w_resp_nxt  = RESP_WAIT;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = c_address;
            w_tmo_nxt   = 16'd0;
            w_state_nxt = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (w_fault) begin
          w_resp_nxt  = RESP_ACCESSFAULT;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_READY;
        end else if (m_ack) begin
          w_resp_nxt      = RESP_DONE;
          w_data_nxt      = m_rdata;
          w_buf_valid_nxt = 1'b1;
          w_buf_addr_nxt  = r_addr;
          w_buf_data_nxt  = m_rdata;
          w_req_nxt       = 1'b0;
          w_state_nxt     = S_READY;
        end else
          w_tmo_nxt = r_tmo_cnt + {15'd0, r_tmo_cnt != 16'hFFFF};
      end
      default: w_state_nxt = S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= 8'd0;
      r_tmo_cnt   <= 16'd0;
      r_resp      <= RESP_IDLE;
      r_data      <= 32'd0;
      r_done      <= 1'b0;
      r_req       <= 1'b0;
      r_addr      <= 32'd0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 32'd0;
      r_buf_data  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_resp      <= w_resp_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_req       <= w_req_nxt;
      r_addr      <= w_addr_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_data  <= w_buf_data_nxt;
    end
  end
  assign c_response   = r_resp;
  assign c_load_data  = r_data;
  assign c_reset_done = r_done;
  assign m_req        = r_req;
  assign m_addr       = r_addr;
endmodule

// File: tb/tb_armleocpu_fetch_bridge.sv
// tb_armleocpu_fetch_bridge: directed plus random fetch traffic against a transaction-level buffer model.
module tb_armleocpu_fetch_bridge;
  localparam int TO = 8;
  localparam logic [31:0] IDLE = 0, WAIT = 1, DONE = 2, AF = 3, MIS = 5;
  logic clk = 0, rst = 1;
  logic [3:0] c_cmd = 0;
  logic [31:0] c_address = 0, c_load_data, m_addr, m_rdata = 0;
  logic [3:0] c_response;
  logic c_reset_done, m_req, m_ack = 0, m_err = 0;
  int checks = 0, errors = 0;
  bit mv = 0;
  logic [31:0] ma = 0, md = 0, exp_data = 0;
  armleocpu_fetch_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .c_cmd(c_cmd), .c_address(c_address),
    .c_response(c_response), .c_load_data(c_load_data), .c_reset_done(c_reset_done),
    .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit in_range(input logic [31:0] a);
    return longint'(a) >= 64'h0 && longint'(a) < 64'h10000;
  endfunction
  task automatic do_reset(input bit stale);
    rst = 1;
    c_cmd = 0;
    step();
    check("rst_req", 32'(m_req), 0);
    check("rst_resp", 32'(c_response), IDLE);
    check("rst_done", 32'(c_reset_done), 0);
    step();
    check("rst_data", c_load_data, 0);
    check("rst_addr", m_addr, 0);
    rst = 0;
    c_cmd = 1;
    c_address = 32'h100;
    m_ack = stale;
    m_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      step();
      m_ack = 0;
      check("init_done", 32'(c_reset_done), 32'(k == 4));
      check("init_req", 32'(m_req), 0);
      check("init_resp", 32'(c_response), IDLE);
    end
    c_cmd = 0;
    mv = 0;
    exp_data = 0;
  endtask
  // err: 0 none, 1 m_err alone, 2 m_err with m_ack; d >= TO means no response
  task automatic do_cmd(input logic [3:0] cmd, input logic [31:0] addr, input int d, input int err, input logic [31:0] data);
    int i;
    bit fire;
    c_cmd = cmd;
    c_address = addr;
    step();
    c_cmd = 0;
    c_address = $urandom;
    if (cmd == 4) begin
      mv = 0;
      check("flush_resp", 32'(c_response), DONE);
      check("flush_data", c_load_data, exp_data);
      check("flush_req", 32'(m_req), 0);
    end else if (cmd != 1) begin
      check("none_resp", 32'(c_response), IDLE);
      check("none_req", 32'(m_req), 0);
    end else if (addr[1:0] != 2'b00) begin
      check("mis_resp", 32'(c_response), MIS);
      check("mis_req", 32'(m_req), 0);
    end else if (!in_range(addr)) begin
      check("range_resp", 32'(c_response), AF);
      check("range_req", 32'(m_req), 0);
    end else if (mv && addr == ma) begin
      exp_data = md;
      check("hit_resp", 32'(c_response), DONE);
      check("hit_data", c_load_data, exp_data);
      check("hit_req", 32'(m_req), 0);
    end else begin
      check("miss_resp", 32'(c_response), WAIT);
      check("miss_req", 32'(m_req), 1);
      check("miss_addr", m_addr, addr);
      i = 0;
      forever begin
        fire = (i == d);
        m_ack = fire && err != 1;
        m_err = fire && err != 0;
        m_rdata = fire ? data : $urandom;
        step();
        m_ack = 0;
        m_err = 0;
        if (fire || i == TO - 1) break;
        check("bus_wait", 32'(c_response), WAIT);
        check("bus_req", 32'(m_req), 1);
        check("bus_addr", m_addr, addr);
        i++;
      end
      check("bus_req_drop", 32'(m_req), 0);
      if (fire && err == 0) begin
        mv = 1;
        ma = addr;
        md = data;
        exp_data = data;
        check("fill_resp", 32'(c_response), DONE);
        check("fill_data", c_load_data, exp_data);
      end else
        check("bus_fault", 32'(c_response), AF);
    end
  endtask
  task automatic abort_mid();
    do_cmd(4, 0, 0, 0, 0);
    c_cmd = 1;
    c_address = 32'h400;
    step();
    c_cmd = 0;
    check("abort_wait", 32'(c_response), WAIT);
    step();
    check("abort_req", 32'(m_req), 1);
    do_reset(1);
  endtask
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h104;
      2: return 32'h200;
      3: return 32'hFFFC;
      4: return 32'h0;
      default: return {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
    endcase
  endfunction
  initial begin
    logic [3:0] odd_cmds [5];
    odd_cmds = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd15};
    do_reset(0);
    do_cmd(1, 32'h100, 0, 0, 32'h13);
    do_cmd(1, 32'h100, 0, 0, 0);
    do_cmd(4, 0, 0, 0, 0);
    do_cmd(1, 32'h100, 2, 0, 32'h0000_0513);
    do_cmd(1, 32'h102, 0, 0, 0);
    do_cmd(1, 32'h0001_0000, 0, 0, 0);
    do_cmd(1, 32'h200, 1, 2, 32'hBAD0_BAD0);
    do_cmd(1, 32'h100, 0, 0, 0);
    do_cmd(1, 32'h300, 100, 0, 0);
    do_cmd(1, 32'h304, TO - 1, 0, 32'h1234_5678);
    do_cmd(0, 0, 0, 0, 0);
    abort_mid();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_cmd(4, 0, 0, 0, 0);
      else if (r == 1) do_cmd(odd_cmds[$urandom_range(0, 4)], pick_addr(), 0, 0, 0);
      else if (r == 2) do_cmd(1, pick_addr() | 32'($urandom_range(1, 3)), 0, 0, 0);
      else if (r == 3) do_cmd(1, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'h0001_0000 + 4 * $urandom_range(0, 99), 0, 0, 0);
      else if (r == 4 && $urandom_range(0, 4) == 0) abort_mid();
      else do_cmd(1, pick_addr(), $urandom_range(0, 9), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/armleocpu_fetch_bridge.md
Name: armleocpu_fetch_bridge

Overview:
- Upstream neighbour of the fetch stage. Answers fetch's cache-interface commands (c_cmd/c_address in, c_response/c_load_data/c_reset_done out) from a simple single-outstanding memory read bus.
- Adds a one-entry last-fetch buffer, alignment and range checks, a bus timeout, and the post-reset init sequence.
- Serves as the uncached/boot instruction path where a full cache is not instantiated.

Parameters:
- INIT_CYCLES, 4: cycles c_reset_done stays low after reset release (1..255).
- MEM_BASE, 32'h0000_0000: lowest fetchable address.
- MEM_SIZE, 32'h0001_0000: fetchable window size in bytes; addresses at or above MEM_BASE+MEM_SIZE fault.
- TIMEOUT, 64: bus cycles without m_ack or m_err before the access faults (1..65535).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- c_cmd  in  4  `CACHE_CMD_* from fetch; only EXECUTE, FLUSH_ALL and NONE are meaningful, any other value is treated as NONE.
- c_address  in  32  fetch address, sampled with c_cmd.
- c_response  out  4  registered `CACHE_RESPONSE_*.
- c_load_data  out  32  instruction word; valid only while c_response == DONE.
- c_reset_done  out  1  high once init completes.
- m_req  out  1  bus read request, held until m_ack, m_err or timeout.
- m_addr  out  32  word-aligned bus address, stable while m_req.
- m_ack  in  1  read complete, m_rdata valid this cycle.
- m_err  in  1  bus error, terminates request.
- m_rdata  in  32  read data.

Behaviour:
- Reset (rst=1 at edge):
  - Outputs: state=INIT, c_response=IDLE, c_reset_done=0, m_req=0, m_addr=0, c_load_data=0.
  - Internal: buffer valid=0, timeout counter=0, init counter=0.
  - Reset mid-bus-transaction drops m_req on the next edge. The bus must tolerate a request withdrawn without ack, and a late ack is ignored.
- INIT: the counter increments each cycle. When it reaches INIT_CYCLES-1, go to READY and set c_reset_done=1. c_cmd is ignored in INIT.
- READY: c_cmd and c_address are sampled on every cycle in which c_response != WAIT. This includes cycles showing DONE or an error, so back-to-back fetches are possible. Priority:
  - FLUSH_ALL: clear buffer valid; next cycle c_response=DONE, c_load_data unchanged.
  - EXECUTE with c_address[1:0] != 0: next cycle MISSALIGNED, no bus access.
  - EXECUTE with address outside [MEM_BASE, MEM_BASE+MEM_SIZE): next cycle ACCESSFAULT. The comparison uses 33-bit arithmetic so MEM_BASE+MEM_SIZE may equal 2^32.
  - EXECUTE with buffer valid and address matching the buffer: next cycle DONE with buffered data (1-cycle hit).
  - EXECUTE otherwise: next cycle c_response=WAIT, m_req=1, m_addr=c_address; go to BUS.
  - NONE: next cycle c_response=IDLE.
- c_response holds DONE or an error for exactly one cycle. It then returns to IDLE unless a new command was sampled in that cycle.
- BUS:
  - m_ack in cycle k: at k+1, c_response=DONE, c_load_data=m_rdata, buffer={address, m_rdata, valid=1}, m_req=0, back to READY.
  - m_err, or timeout counter reaching TIMEOUT-1 without ack: at k+1, c_response=ACCESSFAULT, m_req=0, buffer unchanged.
  - m_ack and m_err in the same cycle: m_err wins.
  - c_cmd is ignored throughout BUS; c_response stays WAIT.
  - Minimum miss latency: command at cycle 0, m_req at 1, ack at 1, DONE at 2.
- Buffer is a single entry; any successful bus read replaces it. Error responses never update it.
- The timeout counter clears on entering BUS and saturates; it is not a wrap-around counter.

Test Plan:
- Init: rst high 2 cycles then low, INIT_CYCLES=4 -> c_reset_done=0 for 4 cycles then 1; EXECUTE issued during INIT produces no m_req.
- Miss then hit: EXECUTE 0x100; m_ack with m_rdata=0x00000013 one cycle after m_req -> WAIT then DONE, data 0x13. Immediate re-EXECUTE 0x100 in the DONE cycle -> DONE next cycle, no m_req.
- Flush: after buffering 0x100, issue FLUSH_ALL -> DONE after 1 cycle. EXECUTE 0x100 then -> m_req=1 (miss).
- Faults:
  - EXECUTE 0x102 -> MISSALIGNED, m_req stays 0.
  - EXECUTE 0x0001_0000 with default parameters -> ACCESSFAULT.
  - m_err together with m_ack -> ACCESSFAULT, buffer not updated.
- Timeout: TIMEOUT=8, m_ack never asserted -> ACCESSFAULT exactly 8 bus cycles after m_req rises, then m_req=0.
- Reset mid-transaction: rst during BUS -> m_req=0, c_response=IDLE, c_reset_done=0 next cycle. A stale m_ack afterwards produces no DONE.
